lcd_read_block: RTL
===================

# lcd_read_block

Read-side controller for the HD44780-style character LCD, the counterpart to the write path that pushes ASCII characters to the panel. On request it runs one read bus cycle (RW=1) with programmable setup, strobe, hold and recovery times. It returns either the busy flag plus address counter, or one DDRAM/CGRAM data byte. A poll mode repeats busy-flag reads until the panel is ready or a poll limit expires, so the write path can gate its next character on a real "not busy" indication instead of a fixed delay.

## Interface
Parameters:
- SETUP_CYC, 4: clocks with RS/RW stable before E rises (tAS).
- EHIGH_CYC, 25: clocks E is high (tPW); the data sample is taken on the last of these.
- HOLD_CYC, 2: clocks RS/RW are held after E falls (tH).
- RECOV_CYC, 25: clocks of bus idle before the next cycle may start (tcycE).
- POLL_MAX, 4096: maximum busy-flag reads in poll mode (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  start request; sampled only while busy=0.
- mode  in  2  00 read BF/AC, 01 read data (RS=1), 10 poll until not busy, 11 treated as 00.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- rd_data  out  8  last raw byte sampled from the panel.
- bf  out  1  rd_data[7] of the last BF/AC read.
- ac  out  7  rd_data[6:0] of the last BF/AC read.
- timeout  out  1  poll ended with BF still 1; valid with done, held until next accept.
- lcd_data_in  in  8  panel data bus, input side.
- lcd_data_oe  out  1  bus drive enable; this block holds it at 0 at all times.
- lcd_rw  out  1  panel RW.
- lcd_rs  out  1  panel RS.
- lcd_e  out  1  panel E strobe.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOV, FINISH.
- IDLE: if req=1, latch mode, clear timeout and the poll counter, set busy=1, go to SETUP.
- SETUP (SETUP_CYC clocks): lcd_rw=1, lcd_rs=(mode==01), lcd_e=0.
- STROBE (EHIGH_CYC clocks): lcd_e=1; on the final clock register lcd_data_in into rd_data. In modes 00, 10 and 11 also update bf and ac.
- HOLD (HOLD_CYC clocks): lcd_e=0, RS/RW held.
- RECOV (RECOV_CYC clocks): lcd_rw=0, lcd_rs=0.
- After RECOV, in mode 10 with bf=1 and poll count < POLL_MAX−1: increment the count and return to SETUP.
- After RECOV, in every other case: go to FINISH.
- FINISH (1 clock): done=1, busy=0. timeout=1 if mode 10 and bf=1. A req in this cycle is accepted; the next state is SETUP.
- req while busy=1 and outside FINISH is ignored. It is not queued.
- One shared down-counter times all phases; it is loaded on each state entry.

## Timing
- Reset values: lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_data_oe=0, busy=0, done=0, timeout=0, rd_data=0, bf=0, ac=0. State is IDLE.
- Reset mid-cycle forces lcd_e low asynchronously. No done is produced.
- req accepted at edge k: busy and lcd_rw are high from k+1.
- lcd_e is high in cycles k+1+S … k+S+E.
- done occurs at k+1+S+E+H+R, which is k+57 with defaults.
- Poll mode: each extra read adds S+E+H+R clocks (56 with defaults).
- Poll worst case: done at k+1+POLL_MAX·(S+E+H+R).
- rd_data, bf and ac change only at the sample clock and are stable from then through done.

## Structure
- Shared package lcd_pkg:
  - mode encodings (MODE_BFAC, MODE_DATA, MODE_POLL);
  - BF bit index 7;
  - default timing constants, shared with the write path.
- Natural sub-module lcd_read_cycle: a single RW=1 bus cycle with start/finished handshake and a sample output.
- lcd_read_block wraps lcd_read_cycle with mode latching, the poll counter and the done/timeout logic.

## Test plan
- Mode 00 with lcd_data_in=8'h45 → lcd_e high for exactly 25 clocks, lcd_rs=0, lcd_rw=1; done at k+57 with bf=0, ac=7'h45, rd_data=8'h45.
- Mode 01 with lcd_data_in=8'h41 → lcd_rs=1 throughout SETUP/STROBE/HOLD; rd_data=8'h41; bf and ac unchanged from the previous read.
- Mode 10, panel drives 8'h80 for 3 reads then 8'h12 → exactly 4 E pulses; done at k+1+4·56; bf=0, ac=7'h12, timeout=0.
- Mode 10 with POLL_MAX=8 and the bus stuck at 8'hFF → 8 E pulses, done with timeout=1, bf=1.
- req pulsed mid-operation, then held high through FINISH → the mid-operation pulse is ignored; the second operation starts in the cycle after done.
- reset asserted during STROBE → lcd_e falls at once, all outputs take their reset values, no done; the next req runs normally.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the HD44780-style LCD read and write paths:
// mode encodings, busy-flag bit position, default bus timing constants
// and the state encodings of the read-side FSMs.
package lcd_pkg;

    // Read request modes (2'b11 is folded onto MODE_BFAC by norm_mode)
    localparam logic [1:0] MODE_BFAC = 2'b00;
    localparam logic [1:0] MODE_DATA = 2'b01;
    localparam logic [1:0] MODE_POLL = 2'b10;

    // Busy flag position within a BF/AC read
    localparam int BF_BIT = 7;

    // Default bus timing in system clocks (shared with the write path)
    localparam int LCD_SETUP_CYC = 4;
    localparam int LCD_EHIGH_CYC = 25;
    localparam int LCD_HOLD_CYC  = 2;
    localparam int LCD_RECOV_CYC = 25;
    localparam int LCD_POLL_MAX  = 4096;

    // Phases of one RW=1 bus cycle
    typedef enum logic [2:0] {
        CYC_IDLE,
        CYC_SETUP,
        CYC_STROBE,
        CYC_HOLD,
        CYC_RECOV
    } cyc_state_t;

    // Request-level sequencing around the bus cycles
    typedef enum logic [1:0] {
        BLK_IDLE,
        BLK_RUN,
        BLK_FINISH
    } blk_state_t;

    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_BFAC : m;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_read_block_if.sv
// lcd_read_block_if
// Request/response handshake and LCD panel bus of the read controller.
//   req, mode        : start request and read mode (requester -> block)
//   busy, done       : operation in progress / one-cycle completion pulse
//   rd_data, bf, ac  : last sampled byte, busy flag, address counter
//   timeout          : poll ended with BF still set (valid with done)
//   lcd_data_in      : panel data bus, input side (panel -> block)
//   lcd_data_oe      : bus drive enable (always 0 for the read path)
//   lcd_rw, lcd_rs, lcd_e : panel control lines
interface lcd_read_block_if;
    logic       req;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       bf;
    logic [6:0] ac;
    logic       timeout;
    logic [7:0] lcd_data_in;
    logic       lcd_data_oe;
    logic       lcd_rw;
    logic       lcd_rs;
    logic       lcd_e;

    // Block side
    modport slave (
        input  req, mode, lcd_data_in,
        output busy, done, rd_data, bf, ac, timeout,
        output lcd_data_oe, lcd_rw, lcd_rs, lcd_e
    );

    // Requester / panel side
    modport master (
        output req, mode, lcd_data_in,
        input  busy, done, rd_data, bf, ac, timeout,
        input  lcd_data_oe, lcd_rw, lcd_rs, lcd_e
    );
endinterface

// File: rtl/lcd_read_cycle.sv
// lcd_read_cycle
// One RW=1 panel bus cycle: SETUP -> STROBE (E high) -> HOLD -> RECOV.
// A single down-counter, loaded on each state entry, times every phase.
// Ports:
//   clk, reset : clock, async active-high reset
//   i_start    : begin a cycle (honoured in IDLE and on the last RECOV clock,
//                so back-to-back cycles chain with no idle gap)
//   i_rs       : RS level for this cycle
//   o_e/o_rw/o_rs : registered panel control lines
//   o_sample   : high on the final E-high clock; the owner captures data then
//   o_last     : high on the final RECOV clock
module lcd_read_cycle
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = LCD_SETUP_CYC,
    parameter int EHIGH_CYC = LCD_EHIGH_CYC,
    parameter int HOLD_CYC  = LCD_HOLD_CYC,
    parameter int RECOV_CYC = LCD_RECOV_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_rs,
    output logic o_e,
    output logic o_rw,
    output logic o_rs,
    output logic o_sample,
    output logic o_last
);

    localparam int CMAX = max4(SETUP_CYC, EHIGH_CYC, HOLD_CYC, RECOV_CYC);
    localparam int CW   = $clog2(CMAX + 1);

    cyc_state_t     r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_e;
    logic           r_rw;
    logic           r_rs;
    logic           w_zero;

    assign w_zero = (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CYC_IDLE;
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_rw    <= 1'b0;
            r_rs    <= 1'b0;
        end else begin
            if (!w_zero) r_cnt <= r_cnt - CW'(1);
            case (r_state)
                CYC_IDLE: begin
                    if (i_start) begin
                        r_state <= CYC_SETUP;
                        r_cnt   <= CW'(SETUP_CYC - 1);
                        r_rw    <= 1'b1;
                        r_rs    <= i_rs;
                    end
                end
                CYC_SETUP: begin
                    if (w_zero) begin
                        r_state <= CYC_STROBE;
                        r_cnt   <= CW'(EHIGH_CYC - 1);
                        r_e     <= 1'b1;
                    end
                end
                CYC_STROBE: begin
                    if (w_zero) begin
                        r_state <= CYC_HOLD;
                        r_cnt   <= CW'(HOLD_CYC - 1);
                        r_e     <= 1'b0;
                    end
                end
                CYC_HOLD: begin
                    if (w_zero) begin
                        r_state <= CYC_RECOV;
                        r_cnt   <= CW'(RECOV_CYC - 1);
                        r_rw    <= 1'b0;
                        r_rs    <= 1'b0;
                    end
                end
                CYC_RECOV: begin
                    if (w_zero) begin
                        if (i_start) begin
                            // Chained cycle (poll retry or back-to-back request)
                            r_state <= CYC_SETUP;
                            r_cnt   <= CW'(SETUP_CYC - 1);
                            r_rw    <= 1'b1;
                            r_rs    <= i_rs;
                        end else begin
                            r_state <= CYC_IDLE;
                        end
                    end
                end
                default: r_state <= CYC_IDLE;
            endcase
        end
    end

    assign o_e      = r_e;
    assign o_rw     = r_rw;
    assign o_rs     = r_rs;
    assign o_sample = (r_state == CYC_STROBE) && w_zero;
    assign o_last   = (r_state == CYC_RECOV) && w_zero;

endmodule

// File: rtl/lcd_read_block.sv
// lcd_read_block
// Read-side LCD controller. Accepts a request, runs one bus cycle (or, in
// poll mode, repeated BF/AC reads until BF clears or POLL_MAX reads are
// done) and reports the result with a one-cycle done pulse.
// Ports:
//   clk, reset : clock, async active-high reset
//   bus        : lcd_read_block_if.slave (request, result and panel bus)
module lcd_read_block
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = LCD_SETUP_CYC,
    parameter int EHIGH_CYC = LCD_EHIGH_CYC,
    parameter int HOLD_CYC  = LCD_HOLD_CYC,
    parameter int RECOV_CYC = LCD_RECOV_CYC,
    parameter int POLL_MAX  = LCD_POLL_MAX
) (
    input  logic             clk,
    input  logic             reset,
    lcd_read_block_if.slave  bus
);

    localparam int PW = $clog2(POLL_MAX + 1);

    blk_state_t    r_state;
    logic [1:0]    r_mode;
    logic [PW-1:0] r_poll;
    logic          r_busy;
    logic          r_done;
    logic          r_timeout;
    logic [7:0]    r_rd;
    logic          r_bf;
    logic [6:0]    r_ac;

    logic w_accept;
    logic w_again;
    logic w_start;
    logic w_rs;
    logic w_sample;
    logic w_last;
    logic w_e;
    logic w_rw;
    logic w_rs_pin;

    // A request is taken in IDLE and also in the FINISH cycle, so a held req
    // starts the next operation immediately after done.
    assign w_accept = ((r_state == BLK_IDLE) || (r_state == BLK_FINISH)) && bus.req;

    // Poll retry decision, made on the last recovery clock of a read
    assign w_again  = (r_state == BLK_RUN) && w_last && (r_mode == MODE_POLL) &&
                      r_bf && (r_poll < PW'(POLL_MAX - 1));

    assign w_start  = w_accept || w_again;

    // On accept the mode is not latched yet, so RS comes from the request
    assign w_rs     = w_accept ? (norm_mode(bus.mode) == MODE_DATA)
                               : (r_mode == MODE_DATA);

    lcd_read_cycle #(
        .SETUP_CYC (SETUP_CYC),
        .EHIGH_CYC (EHIGH_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .RECOV_CYC (RECOV_CYC)
    ) u_cycle (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_rs     (w_rs),
        .o_e      (w_e),
        .o_rw     (w_rw),
        .o_rs     (w_rs_pin),
        .o_sample (w_sample),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= BLK_IDLE;
            r_mode    <= MODE_BFAC;
            r_poll    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_rd      <= 8'h00;
            r_bf      <= 1'b0;
            r_ac      <= 7'h00;
        end else begin
            r_done <= 1'b0;

            if (w_sample) begin
                r_rd <= bus.lcd_data_in;
                if (r_mode != MODE_DATA) begin
                    r_bf <= bus.lcd_data_in[BF_BIT];
                    r_ac <= bus.lcd_data_in[BF_BIT-1:0];
                end
            end

            case (r_state)
                BLK_IDLE, BLK_FINISH: begin
                    if (bus.req) begin
                        r_mode    <= norm_mode(bus.mode);
                        r_timeout <= 1'b0;
                        r_poll    <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= BLK_RUN;
                    end else begin
                        r_state   <= BLK_IDLE;
                    end
                end
                BLK_RUN: begin
                    if (w_last) begin
                        if (w_again) begin
                            r_poll <= r_poll + PW'(1);
                        end else begin
                            r_state   <= BLK_FINISH;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_timeout <= (r_mode == MODE_POLL) && r_bf;
                        end
                    end
                end
                default: r_state <= BLK_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.rd_data     = r_rd;
    assign bus.bf          = r_bf;
    assign bus.ac          = r_ac;
    assign bus.timeout     = r_timeout;
    assign bus.lcd_data_oe = 1'b0;
    assign bus.lcd_rw      = w_rw;
    assign bus.lcd_rs      = w_rs_pin;
    assign bus.lcd_e       = w_e;

endmodule
